data_mem_ctrl: RTL

Parametrised data-memory controller that sits behind the data cache. It is the successor to the current data-memory top. It serves cache-line refills and two kinds of write: single words with byte strobes, and full-line write-backs. Every access pays a programmable access latency, and lines move as one word per cycle. A single FSM arbitrates between the read and write channels.

---
 rtl/data_mem_ctrl_if.sv | 50 +++++
 rtl/data_mem_ctrl.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl_if.sv
// Request/response bundle between the data cache and data_mem_ctrl.
// The cache side uses the master modport and the controller uses the slave modport.
interface data_mem_ctrl_if #(
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int CACHE_LINE_WIDTH = 256
);
   logic                        i_mem_read_req;
   logic [ADDR_WIDTH-1:0]       i_mem_read_address;
   logic                        o_mem_read_done;
   logic [CACHE_LINE_WIDTH-1:0] o_cache_line;
   logic                        i_mem_write_valid;
   logic                        i_write_line;
   logic [ADDR_WIDTH-1:0]       i_mem_write_address;
   logic [DATA_WIDTH-1:0]       i_mem_write_data;
   logic [DATA_WIDTH/8-1:0]     i_write_strobe;
   logic [CACHE_LINE_WIDTH-1:0] i_write_cache_line;
   logic                        o_mem_write_done;
   logic                        o_busy;

   modport master (
      output i_mem_read_req,
      output i_mem_read_address,
      input  o_mem_read_done,
      input  o_cache_line,
      output i_mem_write_valid,
      output i_write_line,
      output i_mem_write_address,
      output i_mem_write_data,
      output i_write_strobe,
      output i_write_cache_line,
      input  o_mem_write_done,
      input  o_busy
   );

   modport slave (
      input  i_mem_read_req,
      input  i_mem_read_address,
      output o_mem_read_done,
      output o_cache_line,
      input  i_mem_write_valid,
      input  i_write_line,
      input  i_mem_write_address,
      input  i_mem_write_data,
      input  i_write_strobe,
      input  i_write_cache_line,
      output o_mem_write_done,
      output o_busy
   );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller behind the data cache: line refills, strobed word writes and
// line write-backs. Each access waits LATENCY cycles, then moves one word per cycle.
module data_mem_ctrl #(
   parameter int MEM_DEPTH        = 12,
   parameter int DATA_WIDTH       = 32,
   parameter int ADDR_WIDTH       = 32,
   parameter int CACHE_LINE_WIDTH = 256,
   parameter int LATENCY          = 4
) (
   input logic            i_clk,
   input logic            i_rst,
   data_mem_ctrl_if.slave bus
);
   localparam int STRB_W     = DATA_WIDTH / 8;
   localparam int BYTE_BITS  = $clog2(STRB_W);
   localparam int LINE_WORDS = CACHE_LINE_WIDTH / DATA_WIDTH;
   localparam int LW_BITS    = $clog2(LINE_WORDS);
   localparam int LAT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int MEM_WORDS  = 1 << MEM_DEPTH;
   localparam logic [LW_BITS-1:0] LAST_BEAT = LW_BITS'(LINE_WORDS - 1);
   localparam logic [LAT_W-1:0]   LAT_LOAD  = LAT_W'(LATENCY - 1);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT    = 3'd1,
      ST_RD_BEAT = 3'd2,
      ST_WR_BEAT = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   logic [DATA_WIDTH-1:0]       mem_r [MEM_WORDS];
   state_t                      state_r;
   logic [LAT_W-1:0]            lat_cnt_r;
   logic [LW_BITS-1:0]          beat_r;
   logic                        is_write_r;
   logic                        line_mode_r;
   logic [MEM_DEPTH-1:0]        idx_r;
   logic [DATA_WIDTH-1:0]       wr_data_r;
   logic [STRB_W-1:0]           strobe_r;
   logic [CACHE_LINE_WIDTH-1:0] wr_line_r;
   logic [CACHE_LINE_WIDTH-1:0] rd_line_r;
   logic                        rd_done_r;
   logic                        wr_done_r;
   logic                        busy_r;

   logic [ADDR_WIDTH-1:0]       acc_addr_s;
   logic                        addr_unused_s;
   logic [MEM_DEPTH-1:0]        beat_idx_s;
   logic                        wr_en_s;
   logic [MEM_DEPTH-1:0]        wr_idx_s;
   logic [STRB_W-1:0]           wr_be_s;
   logic [DATA_WIDTH-1:0]       wr_word_s;

   // Upper address bits are dropped, so the array wraps modulo its size.
   function automatic logic [MEM_DEPTH-1:0] word_index(input logic [ADDR_WIDTH-1:0] addr);
      return addr[MEM_DEPTH+BYTE_BITS-1:BYTE_BITS];
   endfunction

   assign acc_addr_s    = bus.i_mem_write_valid ? bus.i_mem_write_address : bus.i_mem_read_address;
   assign addr_unused_s = ^{acc_addr_s[ADDR_WIDTH-1:MEM_DEPTH+BYTE_BITS], acc_addr_s[BYTE_BITS-1:0]};
   assign beat_idx_s    = {idx_r[MEM_DEPTH-1:LW_BITS], beat_r};

   assign bus.o_mem_read_done  = rd_done_r;
   assign bus.o_mem_write_done = wr_done_r;
   assign bus.o_busy           = busy_r;
   assign bus.o_cache_line     = rd_line_r;

   // Write-port selection: whole words in line mode, strobed bytes in word mode.
   always_comb begin
      wr_en_s   = 1'b0;
      wr_idx_s  = idx_r;
      wr_be_s   = strobe_r;
      wr_word_s = wr_data_r;
      if ((state_r == ST_WR_BEAT) && !i_rst) begin
         wr_en_s = 1'b1;
         if (line_mode_r) begin
            wr_idx_s  = beat_idx_s;
            wr_be_s   = {STRB_W{1'b1}};
            wr_word_s = wr_line_r[int'(beat_r)*DATA_WIDTH +: DATA_WIDTH];
         end else begin
            wr_idx_s  = idx_r;
            wr_be_s   = strobe_r;
            wr_word_s = wr_data_r;
         end
      end else begin
         wr_en_s = 1'b0;
      end
   end

   // Byte-enabled array write; the array contents are not reset.
   always_ff @(posedge i_clk) begin
      if (wr_en_s) begin
         for (int j = 0; j < STRB_W; j++) begin
            if (wr_be_s[j]) begin
               mem_r[wr_idx_s][j*8 +: 8] <= wr_word_s[j*8 +: 8];
            end
         end
      end
   end

   // Arbitration/transfer FSM with registered done, busy and line outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r     <= ST_IDLE;
         lat_cnt_r   <= {LAT_W{1'b0}};
         beat_r      <= {LW_BITS{1'b0}};
         is_write_r  <= 1'b0;
         line_mode_r <= 1'b0;
         idx_r       <= {MEM_DEPTH{1'b0}};
         wr_data_r   <= {DATA_WIDTH{1'b0}};
         strobe_r    <= {STRB_W{1'b0}};
         wr_line_r   <= {CACHE_LINE_WIDTH{1'b0}};
         rd_line_r   <= {CACHE_LINE_WIDTH{1'b0}};
         rd_done_r   <= 1'b0;
         wr_done_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         rd_done_r <= 1'b0;
         wr_done_r <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               // A write wins a tie so that a following read observes it.
               if (bus.i_mem_write_valid) begin
                  is_write_r  <= 1'b1;
                  line_mode_r <= bus.i_write_line;
                  idx_r       <= word_index(acc_addr_s);
                  wr_data_r   <= bus.i_mem_write_data;
                  strobe_r    <= bus.i_write_strobe;
                  wr_line_r   <= bus.i_write_cache_line;
                  lat_cnt_r   <= LAT_LOAD;
                  beat_r      <= {LW_BITS{1'b0}};
                  busy_r      <= 1'b1;
                  state_r     <= ST_WAIT;
               end else if (bus.i_mem_read_req) begin
                  is_write_r  <= 1'b0;
                  line_mode_r <= 1'b1;
                  idx_r       <= word_index(acc_addr_s);
                  lat_cnt_r   <= LAT_LOAD;
                  beat_r      <= {LW_BITS{1'b0}};
                  busy_r      <= 1'b1;
                  state_r     <= ST_WAIT;
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (lat_cnt_r == {LAT_W{1'b0}}) begin
                  beat_r  <= {LW_BITS{1'b0}};
                  state_r <= is_write_r ? ST_WR_BEAT : ST_RD_BEAT;
               end else begin
                  lat_cnt_r <= lat_cnt_r - LAT_W'(1);
               end
            end
            ST_RD_BEAT: begin
               rd_line_r[int'(beat_r)*DATA_WIDTH +: DATA_WIDTH] <= mem_r[beat_idx_s];
               if (beat_r == LAST_BEAT) begin
                  rd_done_r <= 1'b1;
                  state_r   <= ST_DONE;
               end else begin
                  beat_r <= beat_r + LW_BITS'(1);
               end
            end
            ST_WR_BEAT: begin
               if (!line_mode_r || (beat_r == LAST_BEAT)) begin
                  wr_done_r <= 1'b1;
                  state_r   <= ST_DONE;
               end else begin
                  beat_r <= beat_r + LW_BITS'(1);
               end
            end
            ST_DONE: begin
               beat_r  <= {LW_BITS{1'b0}};
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
